// File: rtl/io_bus_bridge_pkg.sv
// Shared constants and encodings for the io_bus_bridge memory-bus endpoint.
package io_bus_bridge_pkg;

    // I/O window base and register offsets within the window
    localparam logic [17:0] IO_BASE = 18'h30000;
    localparam logic [15:0] IO_UART = 16'h0000;
    localparam logic [15:0] IO_CNT  = 16'h0004;

    // Source of the byte returned on the cycle after an accepted read
    typedef enum logic [2:0] {
        SEL_RAM  = 3'd0,
        SEL_RX   = 3'd1,
        SEL_CNT0 = 3'd2,
        SEL_CNT1 = 3'd3,
        SEL_CNT2 = 3'd4,
        SEL_CNT3 = 3'd5,
        SEL_ZERO = 3'd6
    } sel_t;

    // Program-stop sequencing
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } stop_state_t;

    function automatic logic is_io(input logic [17:0] addr);
        return addr[17:16] == IO_BASE[17:16];
    endfunction

endpackage

// File: rtl/io_bus_bridge_tx_fifo.sv
// io_tx_fifo: byte FIFO feeding the UART transmitter. Pointers carry one
// extra MSB so full and empty are told apart without a separate flag.
module io_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               push_data,
    output logic                     full,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [7:0]  store [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = wr_ptr - rd_ptr;
    assign pop_data = store[rd_ptr[AW-1:0]];
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;

    // Pointer advance; a full-FIFO push is simply not taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Data storage, no reset needed since empty gates every read
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/io_bus_bridge.sv
// io_bus_bridge: decodes CPU byte accesses into RAM pass-through or the I/O
// window at 0x30000 (UART TX FIFO, UART RX byte, cycle counter, stop).
// Optional RX path is built when IO_BUS_BRIDGE_RX_EN is defined.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_RUN   | normal operation, I/O writes are serviced
// ST_DRAIN | stop requested; I/O writes ignored, TX FIFO emptying
// ST_HALT  | TX drained, stop_o held high until reset
module io_bus_bridge
    import io_bus_bridge_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in_n,
    input  logic        rdy_in,
    input  logic [31:0] mem_a_i,
    input  logic        mem_wr_i,
    input  logic [7:0]  mem_dout_i,
    output logic [7:0]  mem_din_o,
    output logic        io_buffer_full_o,
    output logic [16:0] ram_a_o,
    output logic        ram_we_o,
    output logic [7:0]  ram_din_o,
    input  logic [7:0]  ram_dout_i,
    output logic [7:0]  tx_dat_o,
    output logic        tx_vld_o,
    input  logic        tx_rdy_i,
    input  logic [7:0]  rx_dat_i,
    input  logic        rx_vld_i,
    output logic        rx_rdy_o,
    output logic        stop_o,
    output logic        ovf_o
);

    localparam int CW = $clog2(FIFO_DEPTH);

    stop_state_t   state;
    sel_t          sel_q;
    logic [31:0]   cyc_cnt;
    logic [31:0]   cnt_snap;
    logic          io;
    logic [15:0]   off;
    logic          acc_rd;
    logic          acc_wr;
    logic          uart_hit;
    logic          cnt_hit;
    logic          cnt_base;
    logic          io_wr_en;
    logic          push_req;
    logic [7:0]    push_data;
    logic          stop_req;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW:0]   fifo_count;
    logic          unused_addr;

    assign unused_addr = ^mem_a_i[31:18];

    assign io       = is_io(mem_a_i[17:0]);
    assign off      = mem_a_i[15:0];
    assign acc_rd   = rdy_in & ~mem_wr_i;
    assign acc_wr   = rdy_in & mem_wr_i;
    assign uart_hit = io && (off == IO_UART);
    assign cnt_hit  = io && (off[15:2] == IO_CNT[15:2]);
    assign cnt_base = io && (off == IO_CNT);

    assign ram_a_o   = mem_a_i[16:0];
    assign ram_din_o = mem_dout_i;
    assign ram_we_o  = mem_wr_i & ~io & rdy_in;

    // Once a stop is requested the I/O window no longer accepts writes
    assign io_wr_en  = acc_wr & io & (state == ST_RUN);
    assign push_req  = io_wr_en & ((uart_hit & (|mem_dout_i)) | cnt_base);
    assign push_data = cnt_base ? 8'h00 : mem_dout_i;
    assign stop_req  = io_wr_en & cnt_base;

    io_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk_in),
        .rst_n     (rst_in_n),
        .push      (push_req),
        .push_data (push_data),
        .full      (fifo_full),
        .pop       (tx_vld_o & tx_rdy_i),
        .pop_data  (tx_dat_o),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign tx_vld_o         = ~fifo_empty;
    assign io_buffer_full_o = (FIFO_DEPTH - 32'(fifo_count)) <= FULL_MARGIN;

    // Free-running cycle counter, frozen while the CPU side is stalled
    always_ff @(posedge clk_in) begin
        if (!rst_in_n) cyc_cnt <= '0;
        else if (rdy_in) cyc_cnt <= cyc_cnt + 32'd1;
    end

    // Snapshot taken on the low-byte read keeps the four byte reads coherent
    always_ff @(posedge clk_in) begin
        if (!rst_in_n) cnt_snap <= '0;
        else if (acc_rd && cnt_base) cnt_snap <= cyc_cnt;
    end

`ifdef IO_BUS_BRIDGE_RX_EN
    logic [7:0] rx_q;
    logic       rx_pop;

    assign rx_pop = acc_rd & uart_hit & rx_vld_i;

    // Latch the RX byte at request time and pop it from the receiver
    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            rx_q     <= '0;
            rx_rdy_o <= 1'b0;
        end else begin
            rx_rdy_o <= rx_pop;
            if (rx_pop) rx_q <= rx_dat_i;
        end
    end
`else
    logic unused_rx;

    assign unused_rx = ^{rx_dat_i, rx_vld_i};
    assign rx_rdy_o  = 1'b0;
`endif

    // Remember where the next cycle's read data comes from
    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            sel_q <= SEL_ZERO;
        end else if (acc_rd) begin
            if (!io) begin
                sel_q <= SEL_RAM;
            end else if (uart_hit) begin
`ifdef IO_BUS_BRIDGE_RX_EN
                sel_q <= rx_vld_i ? SEL_RX : SEL_ZERO;
`else
                sel_q <= SEL_ZERO;
`endif
            end else if (cnt_hit) begin
                case (off[1:0])
                    2'd0:    sel_q <= SEL_CNT0;
                    2'd1:    sel_q <= SEL_CNT1;
                    2'd2:    sel_q <= SEL_CNT2;
                    default: sel_q <= SEL_CNT3;
                endcase
            end else begin
                sel_q <= SEL_ZERO;
            end
        end
    end

    // Read-return mux
    always_comb begin
        mem_din_o = 8'h00;
        case (sel_q)
            SEL_RAM:  mem_din_o = ram_dout_i;
`ifdef IO_BUS_BRIDGE_RX_EN
            SEL_RX:   mem_din_o = rx_q;
`endif
            SEL_CNT0: mem_din_o = cnt_snap[7:0];
            SEL_CNT1: mem_din_o = cnt_snap[15:8];
            SEL_CNT2: mem_din_o = cnt_snap[23:16];
            SEL_CNT3: mem_din_o = cnt_snap[31:24];
            default:  mem_din_o = 8'h00;
        endcase
    end

    // Dropped pushes are remembered until reset
    always_ff @(posedge clk_in) begin
        if (!rst_in_n) ovf_o <= 1'b0;
        else if (push_req && fifo_full) ovf_o <= 1'b1;
    end

    // Stop sequencing: wait for the TX FIFO (including the stop marker) to empty
    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            state  <= ST_RUN;
            stop_o <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (stop_req) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state  <= ST_HALT;
                        stop_o <= 1'b1;
                    end
                end
                ST_HALT: begin
                    stop_o <= 1'b1;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule
